// File: rtl/psum_drain_unit.sv
// Psum drain stage: captures psum GBF words, quantizes each lane, and streams the results out of a FIFO.
// Optional macro PSUM_DRAIN_RELU_EN forces negative lanes to zero before the shift.
module psum_drain_unit #(
  parameter int PSUM_GBF_DATA_BITWIDTH = 512,
  parameter int OUT_BITWIDTH           = 16,
  parameter int QUANT_BITWIDTH         = 8,
  parameter int FIFO_DEPTH             = 8,
  parameter int CNT_BITWIDTH           = 16
) (
  input  logic                                                     clk,
  input  logic                                                     reset,
  input  logic                                                     start,
  input  logic [CNT_BITWIDTH-1:0]                                  cfg_word_count,
  input  logic [3:0]                                               cfg_shift,
  input  logic [PSUM_GBF_DATA_BITWIDTH-1:0]                        r_data1b,
  input  logic [PSUM_GBF_DATA_BITWIDTH-1:0]                        r_data2b,
  input  logic                                                     r_en1b_out,
  input  logic                                                     r_en2b_out,
  output logic                                                     out_valid,
  input  logic                                                     out_ready,
  output logic [(PSUM_GBF_DATA_BITWIDTH/OUT_BITWIDTH)*QUANT_BITWIDTH-1:0] out_data,
  output logic                                                     out_last,
  output logic                                                     busy,
  output logic                                                     done,
  output logic                                                     overflow,
  output logic                                                     unexpected
);

  localparam int LANES = PSUM_GBF_DATA_BITWIDTH / OUT_BITWIDTH;
  localparam int QW    = LANES * QUANT_BITWIDTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int OCC_W = AW + 1;
  localparam logic signed [OUT_BITWIDTH-1:0] QMAX = OUT_BITWIDTH'(2**(QUANT_BITWIDTH-1) - 1);
  localparam logic signed [OUT_BITWIDTH-1:0] QMIN = OUT_BITWIDTH'(-(2**(QUANT_BITWIDTH-1)));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  typedef struct packed {
    logic          last;
    logic [QW-1:0] data;
  } entry_t;

  function automatic logic [QW-1:0] quantize(input logic [PSUM_GBF_DATA_BITWIDTH-1:0] word,
                                             input logic [3:0] shift);
    logic [QW-1:0]                  q;
    logic signed [OUT_BITWIDTH-1:0] x;
    logic signed [OUT_BITWIDTH-1:0] v;
    q = '0;
    for (int i = 0; i < LANES; i++) begin
      x = word[i*OUT_BITWIDTH +: OUT_BITWIDTH];
`ifdef PSUM_DRAIN_RELU_EN
      if (x < 0) x = '0;
`endif
      v = x >>> shift;
      if (v > QMAX)      v = QMAX;
      else if (v < QMIN) v = QMIN;
      q[i*QUANT_BITWIDTH +: QUANT_BITWIDTH] = v[QUANT_BITWIDTH-1:0];
    end
    return q;
  endfunction

  state_t                  r_state;
  logic [CNT_BITWIDTH-1:0] r_cfg_cnt;
  logic [3:0]              r_shift;
  logic [CNT_BITWIDTH-1:0] r_cnt;
  logic                    r_last_lost;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_overflow;
  logic                    r_unexpected;
  entry_t                  r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [OCC_W-1:0]        r_occ;

  logic                    w_run;
  logic                    w_trim;
  logic [1:0]              w_n_arr;
  logic [1:0]              w_n_acc;
  logic [1:0]              w_n_push;
  logic [OCC_W-1:0]        w_free;
  logic                    w_pop;
  logic [CNT_BITWIDTH:0]   w_cnt_next;
  logic                    w_job_end;
  logic                    w_last_a;
  logic                    w_last_b;
  logic                    w_last_lost;
  logic                    w_unexp_set;
  logic [QW-1:0]           w_q_a;
  logic [QW-1:0]           w_q_b;
  entry_t                  w_head;

  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = (r_occ != '0);
  assign out_data  = out_valid ? w_head.data : '0;
  assign out_last  = out_valid && w_head.last;
  assign busy       = r_busy;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign unexpected = r_unexpected;

  assign w_pop   = out_valid && out_ready;
  assign w_run   = (r_state == S_RUN);
  assign w_n_arr = {1'b0, r_en1b_out} + {1'b0, r_en2b_out};

  // With a single word left and both buffers valid, buf1 is taken and buf2 is surplus.
  assign w_trim  = w_run && r_en1b_out && r_en2b_out && ((r_cfg_cnt - r_cnt) == CNT_BITWIDTH'(1));
  assign w_n_acc = !w_run ? 2'd0 : (w_trim ? 2'd1 : w_n_arr);

  assign w_q_a = quantize(r_en1b_out ? r_data1b : r_data2b, r_shift);
  assign w_q_b = quantize(r_data2b, r_shift);

  assign w_cnt_next = {1'b0, r_cnt} + (CNT_BITWIDTH+1)'(w_n_acc);
  assign w_job_end  = (w_n_acc != 2'd0) && (w_cnt_next == {1'b0, r_cfg_cnt});
  assign w_last_a   = w_job_end && (w_n_acc == 2'd1);
  assign w_last_b   = w_job_end && (w_n_acc == 2'd2);

  // A slot freed by this cycle's pop is usable by this cycle's push.
  assign w_free   = OCC_W'(FIFO_DEPTH) - r_occ + OCC_W'(w_pop);
  assign w_n_push = (OCC_W'(w_n_acc) <= w_free) ? w_n_acc : w_free[1:0];

  assign w_last_lost = (w_last_a && (w_n_push == 2'd0)) || (w_last_b && (w_n_push != 2'd2));
  assign w_unexp_set = (!w_run && (r_en1b_out || r_en2b_out)) || w_trim;

  // NOTE: FIFO storage is not reset; out_valid gates every read, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (w_n_push != 2'd0) r_mem[r_wr_ptr]          <= '{last: w_last_a, data: w_q_a};
    if (w_n_push == 2'd2) r_mem[r_wr_ptr + AW'(1)] <= '{last: w_last_b, data: w_q_b};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cfg_cnt    <= '0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_last_lost  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_unexpected <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_n_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_occ    <= r_occ + OCC_W'(w_n_push) - OCC_W'(w_pop);

      r_overflow   <= (r_overflow && !(r_state == S_IDLE && start)) || (w_n_push != w_n_acc);
      r_unexpected <= (r_unexpected && !(r_state == S_IDLE && start)) || w_unexp_set;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cfg_cnt   <= cfg_word_count;
            r_shift     <= cfg_shift;
            r_cnt       <= '0;
            r_last_lost <= 1'b0;
            r_busy      <= 1'b1;
            if (cfg_word_count == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_cnt       <= w_cnt_next[CNT_BITWIDTH-1:0];
          r_last_lost <= r_last_lost || w_last_lost;
          if (w_job_end) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          // If the tagged word was dropped on overflow, draining the FIFO ends the job instead.
          if ((w_pop && w_head.last) || (r_last_lost && r_occ == '0)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
